// File: rtl/eth_idma_launch_ctrl.sv
// Launch controller between a register-file launch strobe and an iDMA backend.
// It queues launches, issues paced requests, tracks in-flight transfers, and keeps completion/error counters and a sticky irq.
module eth_idma_launch_ctrl #(
    parameter int unsigned MaxPending     = 4,
    parameter int unsigned MaxOutstanding = 3,
    parameter int unsigned CntWidth       = 16
) (
    input  logic                                clk_i,
    input  logic                                rst_ni,
    input  logic                                launch_i,
    output logic                                launch_drop_o,
    output logic                                req_valid_o,
    input  logic                                req_ready_i,
    input  logic                                rsp_valid_i,
    output logic                                rsp_ready_o,
    input  logic                                rsp_error_i,
    input  logic                                rsp_last_i,
    input  logic                                irq_clr_i,
    output logic                                irq_o,
    output logic                                busy_o,
    output logic [$clog2(MaxPending+1)-1:0]     pending_o,
    output logic [$clog2(MaxOutstanding+1)-1:0] outstanding_o,
    output logic [CntWidth-1:0]                 done_cnt_o,
    output logic [CntWidth-1:0]                 err_cnt_o
);

    localparam int unsigned PendW = $clog2(MaxPending + 1);
    localparam int unsigned OutW  = $clog2(MaxOutstanding + 1);
    localparam logic [PendW-1:0]    PendMax = PendW'(MaxPending);
    localparam logic [OutW-1:0]     OutMax  = OutW'(MaxOutstanding);
    localparam logic [PendW-1:0]    PendOne = PendW'(1);
    localparam logic [OutW-1:0]     OutOne  = OutW'(1);
    localparam logic [CntWidth-1:0] CntOne  = CntWidth'(1);

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StReq  = 2'd1,
        StGap  = 2'd2
    } state_e;

    state_e              state_q, state_d;
    logic                req_valid_q;
    logic                drop_q;
    logic                irq_q;
    logic [PendW-1:0]    pending_q, pending_d;
    logic [OutW-1:0]     outstanding_q, outstanding_d;
    logic [CntWidth-1:0] done_q, err_q;

    logic req_hs, rsp_hs, launch_ok, launch_drop, issue_ok;

    assign req_hs      = req_valid_q & req_ready_i;
    assign rsp_ready_o = (outstanding_q != '0);
    assign rsp_hs      = rsp_valid_i & rsp_ready_o;
    // A full queue still accepts a launch when a slot frees in the same cycle.
    assign launch_ok   = launch_i & ((pending_q != PendMax) | req_hs);
    assign launch_drop = launch_i & ~launch_ok;
    assign issue_ok    = (pending_q != '0) && (outstanding_q < OutMax);

    // GAP forces one low cycle after a handshake, then decides like IDLE.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle:  if (issue_ok) state_d = StReq;
            StReq:   if (req_ready_i) state_d = StGap;
            StGap:   state_d = issue_ok ? StReq : StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        pending_d = pending_q;
        unique case ({launch_ok, req_hs})
            2'b10:   pending_d = pending_q + PendOne;
            2'b01:   pending_d = pending_q - PendOne;
            default: pending_d = pending_q;
        endcase
    end

    always_comb begin
        outstanding_d = outstanding_q;
        unique case ({req_hs, rsp_hs})
            2'b10:   outstanding_d = outstanding_q + OutOne;
            2'b01:   outstanding_d = outstanding_q - OutOne;
            default: outstanding_d = outstanding_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q       <= StIdle;
            req_valid_q   <= 1'b0;
            pending_q     <= '0;
            outstanding_q <= '0;
            drop_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_valid_q   <= (state_d == StReq);
            pending_q     <= pending_d;
            outstanding_q <= outstanding_d;
            drop_q        <= launch_drop;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            done_q <= '0;
            err_q  <= '0;
            irq_q  <= 1'b0;
        end else begin
            if (rsp_hs) begin
                done_q <= done_q + CntOne;
                if (rsp_error_i) err_q <= err_q + CntOne;
            end
            // Setting beats a simultaneous clear so no completion event is lost.
            if (rsp_hs && (rsp_last_i || rsp_error_i)) irq_q <= 1'b1;
            else if (irq_clr_i)                        irq_q <= 1'b0;
        end
    end

    assign launch_drop_o = drop_q;
    assign req_valid_o   = req_valid_q;
    assign irq_o         = irq_q;
    assign pending_o     = pending_q;
    assign outstanding_o = outstanding_q;
    assign done_cnt_o    = done_q;
    assign err_cnt_o     = err_q;
    assign busy_o        = (pending_q != '0) | (outstanding_q != '0) | req_valid_q;

endmodule
